// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and helpers for the pipeline hazard controller.
//   STG_F..STG_W : bit positions of each pipeline stage in the stall/flush vectors
//   FWD_NONE     : forwarding select value meaning "take the register file"
//   sel_width()  : width of a forwarding select for a given producer count
package hazard_pkg;

  localparam int unsigned STG_F = 0;
  localparam int unsigned STG_D = 1;
  localparam int unsigned STG_E = 2;
  localparam int unsigned STG_M = 3;
  localparam int unsigned STG_W = 4;

  localparam int unsigned FWD_NONE = 0;

  function automatic int unsigned sel_width(input int unsigned nfwd);
    return $clog2(nfwd + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: E-stage forwarding bus between the datapath and hazard_ctrl.
//   src_addrE   : NSRC*REGW  E-stage source register numbers
//   fwd_we      : NFWD       producer k writes a register
//   fwd_addr    : NFWD*REGW  producer k destination register
//   fwd_pending : NFWD       producer k result not yet available
//   fwd_sel     : NSRC*SELW  per-operand bypass select (0 = register file)
// master = datapath side, slave = hazard controller side.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int unsigned NFWD = 2,
  parameter int unsigned NSRC = 2,
  parameter int unsigned REGW = 5
);
  localparam int unsigned SELW = sel_width(NFWD);

  logic [NSRC*REGW-1:0] src_addrE;
  logic [NFWD-1:0]      fwd_we;
  logic [NFWD*REGW-1:0] fwd_addr;
  logic [NFWD-1:0]      fwd_pending;
  logic [NSRC*SELW-1:0] fwd_sel;

  modport master (
    output src_addrE, fwd_we, fwd_addr, fwd_pending,
    input  fwd_sel
  );

  modport slave (
    input  src_addrE, fwd_we, fwd_addr, fwd_pending,
    output fwd_sel
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: priority forwarding match for one E-stage operand.
//   src_addr    : operand register number
//   fwd_we      : producer write enables (index 0 = youngest)
//   fwd_addr    : producer destination registers
//   fwd_pending : producer result not yet available
//   sel         : 0 = register file, k = producer k-1
//   luse        : selected producer is still pending (load-use hazard)
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned NFWD = 2,
  parameter int unsigned REGW = 5,
  parameter int unsigned SELW = 2
) (
  input  logic [REGW-1:0]      src_addr,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*REGW-1:0] fwd_addr,
  input  logic [NFWD-1:0]      fwd_pending,
  output logic [SELW-1:0]      sel,
  output logic                 luse
);

  // Scan oldest to youngest so the lowest-index match is written last and wins.
  always_comb begin
    sel  = SELW'(FWD_NONE);
    luse = 1'b0;
    for (int unsigned i = 0; i < NFWD; i++) begin
      int unsigned k;
      k = NFWD - 1 - i;
      if (fwd_we[k] && (fwd_addr[k*REGW +: REGW] == src_addr) && (src_addr != '0)) begin
        sel  = SELW'(k + 1);
        luse = fwd_pending[k];
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush and operand-forwarding control for the 5-stage core.
//   clk, rst              : clock, synchronous active-high reset
//   i_cache_stall,
//   d_cache_stall,
//   div_stallE            : long-latency freezes (any one freezes the pipe)
//   flush_exceptionM      : exception/eret committed in M
//   flush_pred_failedM    : branch mispredict resolved in M
//   flush_jump_conflictE  : jr/jalr operand conflict resolved in E
//   fwd_bus               : forwarding bus (hazard_ctrl_if.slave)
//   stall, flush          : per-stage controls, bit0=F .. bit4=W
// Optional (HAZARD_PERF_EN): stall_cycles, flush_events performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NFWD = 2,
  parameter int unsigned NSRC = 2,
  parameter int unsigned REGW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cache_stall,
  input  logic          d_cache_stall,
  input  logic          div_stallE,
  input  logic          flush_exceptionM,
  input  logic          flush_pred_failedM,
  input  logic          flush_jump_conflictE,
  hazard_ctrl_if.slave  fwd_bus,
  output logic [4:0]    stall,
  output logic [4:0]    flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_events
`endif
);

  localparam int unsigned SELW = sel_width(NFWD);

  logic [SELW-1:0] sel_op [NSRC];
  logic [NSRC-1:0] luse_op;
  logic            luse;
  logic            longest;
  logic            pend_pred;
  logic            pend_jump;
  logic            pred;
  logic            jump;
  logic [4:0]      stall_c;
  logic [4:0]      flush_c;

  for (genvar j = 0; j < NSRC; j++) begin : g_op
    hazard_fwd_sel #(
      .NFWD (NFWD),
      .REGW (REGW),
      .SELW (SELW)
    ) u_fwd_sel (
      .src_addr    (fwd_bus.src_addrE[j*REGW +: REGW]),
      .fwd_we      (fwd_bus.fwd_we),
      .fwd_addr    (fwd_bus.fwd_addr),
      .fwd_pending (fwd_bus.fwd_pending),
      .sel         (sel_op[j]),
      .luse        (luse_op[j])
    );
  end

  always_comb begin
    fwd_bus.fwd_sel = '0;
    for (int unsigned j = 0; j < NSRC; j++) begin
      fwd_bus.fwd_sel[j*SELW +: SELW] = sel_op[j];
    end
  end

  assign luse    = |luse_op;
  assign longest = i_cache_stall | d_cache_stall | div_stallE;

  // Redirects seen during a freeze are held until the first unfrozen cycle,
  // which is also the cycle the held request is issued, so it fires once.
  always_ff @(posedge clk) begin
    if (rst || flush_exceptionM) begin
      pend_pred <= 1'b0;
      pend_jump <= 1'b0;
    end else if (longest) begin
      pend_pred <= pend_pred | flush_pred_failedM;
      pend_jump <= pend_jump | flush_jump_conflictE;
    end else begin
      pend_pred <= 1'b0;
      pend_jump <= 1'b0;
    end
  end

  assign pred = (flush_pred_failedM   | pend_pred) & ~longest;
  assign jump = (flush_jump_conflictE | pend_jump) & ~longest;

  always_comb begin
    stall_c        = '0;
    flush_c        = '0;
    stall_c[STG_F] = (longest & ~flush_exceptionM) | luse;
    stall_c[STG_D] = longest | luse;
    stall_c[STG_E] = longest | luse;
    stall_c[STG_M] = longest;
    stall_c[STG_W] = longest;
    flush_c[STG_D] = flush_exceptionM | pred | jump;
    flush_c[STG_E] = flush_exceptionM | pred;
    // Load-use bubble into M; dropped when E itself is being flushed.
    flush_c[STG_M] = flush_exceptionM | (luse & ~longest & ~pred);
  end

  assign stall = rst ? '0 : stall_c;
  assign flush = rst ? '0 : flush_c;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall[STG_E]) stall_cycles <= stall_cycles + 32'd1;
      if (flush[STG_D]) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule
